// File: rtl/adc_cap_pkg.sv
// Shared constants for the ADC capture buffer: default geometry and the
// control-FSM state encoding.
package adc_cap_pkg;

    localparam int DEF_DEPTH  = 16;
    localparam int DEF_DATA_W = 8;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_CAPTURE = 2'd1;
    localparam logic [1:0] ST_DRAIN   = 2'd2;

endpackage

// File: rtl/adc_cap_if.sv
// Read-side bundle between the capture buffer (slave) and the SPI shift
// stage (master) that pops one sample per transferred byte.
interface adc_cap_if
    import adc_cap_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH
);
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic              rd_req;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              empty;
    logic              full;
    logic [LVL_W-1:0]  level;

    modport master (
        output rd_req,
        input  rd_data, rd_valid, empty, full, level
    );

    modport slave (
        input  rd_req,
        output rd_data, rd_valid, empty, full, level
    );

endinterface

// File: rtl/adc_cap_fifo.sv
// Synchronous FIFO with flush, registered pop data and registered status.
// Level is an explicit counter; pointers simply wrap modulo DEPTH.
module adc_cap_fifo
    import adc_cap_pkg::*;
#(
    parameter  int DEPTH  = DEF_DEPTH,
    parameter  int DATA_W = DEF_DATA_W,
    localparam int AW     = $clog2(DEPTH),
    localparam int LVL_W  = AW + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              empty,
    output logic              full,
    output logic [LVL_W-1:0]  level,
    output logic              push_drop,
    output logic              fill_next,
    output logic              empty_next
);

    // NOTE: storage has no reset so it can map onto distributed RAM; the
    // pointers and level counter alone define which entries are valid.
    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              do_push;
    logic              do_pop;
    logic [LVL_W-1:0]  level_nxt;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        do_pop    = pop && !empty && !flush;
        do_push   = push && !flush && (!full || do_pop);
        push_drop = push && !flush && full && !do_pop;
        level_nxt = level;
        if (flush)
            level_nxt = '0;
        else if (do_push && !do_pop)
            level_nxt = level + LVL_W'(1);
        else if (do_pop && !do_push)
            level_nxt = level - LVL_W'(1);
    end

    assign fill_next  = (level_nxt == LVL_W'(DEPTH));
    assign empty_next = (level_nxt == '0);

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= wr_data;
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            empty    <= 1'b1;
            full     <= 1'b0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (do_push)
                    wr_ptr <= wr_ptr + AW'(1);
                if (do_pop)
                    rd_ptr <= rd_ptr + AW'(1);
            end
            level    <= level_nxt;
            empty    <= (level_nxt == '0);
            full     <= (level_nxt == LVL_W'(DEPTH));
            rd_valid <= do_pop;
            if (do_pop)
                rd_data <= mem[rd_ptr];
        end
    end

endmodule

// File: rtl/adc_capture_buf.sv
// ADC capture buffer: registers the raw ADC bus, decimates it into a FIFO
// during an armed capture run, then lets the SPI side drain the samples.
module adc_capture_buf
    import adc_cap_pkg::*;
#(
    parameter int DEPTH  = DEF_DEPTH,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] adc_d,
    input  logic [7:0]        decim,
    input  logic              arm,
    input  logic              abort,
    output logic              busy,
    output logic              overflow,
    adc_cap_if.slave          rd_if
);

    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic [1:0]        state;
    logic [7:0]        dec_cnt;
    logic [DATA_W-1:0] sample_q;
    logic              flush;
    logic              dec_hit;
    logic              push_req;
    logic              push_drop;
    logic              fill_next;
    logic              empty_next;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              empty;
    logic              full;
    logic [LVL_W-1:0]  level;

    always_comb begin
        flush    = (state == ST_IDLE) && arm;
        dec_hit  = (dec_cnt == decim);
        push_req = (state == ST_CAPTURE) && !abort && dec_hit;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            dec_cnt  <= '0;
            sample_q <= '0;
            overflow <= 1'b0;
        end else begin
            sample_q <= adc_d;
            case (state)
                ST_IDLE: begin
                    if (arm) begin
                        state    <= ST_CAPTURE;
                        dec_cnt  <= '0;
                        overflow <= 1'b0;
                    end
                end
                ST_CAPTURE: begin
                    // An abort cycle ends the run without storing its sample.
                    if (abort) begin
                        state <= ST_DRAIN;
                    end else begin
                        dec_cnt <= dec_hit ? 8'd0 : dec_cnt + 8'd1;
                        if (push_drop)
                            overflow <= 1'b1;
                        if (fill_next)
                            state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (empty_next)
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy = (state == ST_CAPTURE);

    adc_cap_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .push       (push_req),
        .pop        (rd_if.rd_req),
        .wr_data    (sample_q),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .empty      (empty),
        .full       (full),
        .level      (level),
        .push_drop  (push_drop),
        .fill_next  (fill_next),
        .empty_next (empty_next)
    );

    assign rd_if.rd_data  = rd_data;
    assign rd_if.rd_valid = rd_valid;
    assign rd_if.empty    = empty;
    assign rd_if.full     = full;
    assign rd_if.level    = level;

endmodule

// File: tb/tb_adc_capture_buf.sv
// Self-checking bench for adc_capture_buf: a vector table, directed corner
// sequences and random traffic, all compared against a queue-based model.
module tb_adc_capture_buf;

    localparam int DEPTH = 16;
    localparam int DW    = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] adc_d;
    logic [7:0]    decim;
    logic          arm;
    logic          abort;
    logic          busy;
    logic          overflow;

    adc_cap_if #(.DATA_W(DW), .DEPTH(DEPTH)) rd_if ();

    adc_capture_buf #(.DEPTH(DEPTH), .DATA_W(DW)) dut (
        .clk      (clk),
        .rst      (rst),
        .adc_d    (adc_d),
        .decim    (decim),
        .arm      (arm),
        .abort    (abort),
        .busy     (busy),
        .overflow (overflow),
        .rd_if    (rd_if)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: a sample queue plus run phase, decimation phase and
    // the one-clock-old ADC value.
    typedef enum {M_IDLE, M_CAP, M_DRAIN} m_state_t;
    m_state_t      m_state;
    logic [DW-1:0] m_q[$];
    logic [7:0]    m_cnt;
    logic [DW-1:0] m_sample;
    logic [DW-1:0] m_rd_data;
    bit            m_rd_valid;
    bit            m_ovf;

    typedef struct {
        bit            arm;
        bit            abort;
        bit            rd_req;
        int            level;
        bit            busy;
        bit            empty;
        bit            rd_valid;
        logic [DW-1:0] data;
    } vec_t;

    vec_t tbl[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_state    = M_IDLE;
        m_q.delete();
        m_cnt      = 8'd0;
        m_sample   = '0;
        m_rd_data  = '0;
        m_rd_valid = 1'b0;
        m_ovf      = 1'b0;
    endfunction

    function automatic void model_edge(input bit a, input bit ab, input bit rr,
                                       input logic [7:0] d, input logic [DW-1:0] x);
        int pre    = m_q.size();
        bit popped = 1'b0;
        bit pushed = 1'b0;
        bit want   = 1'b0;
        m_rd_valid = 1'b0;
        if (m_state == M_IDLE && a) begin
            m_q.delete();
            m_ovf   = 1'b0;
            m_cnt   = 8'd0;
            m_state = M_CAP;
        end else begin
            if (m_state == M_CAP && !ab) begin
                want  = (m_cnt == d);
                m_cnt = want ? 8'd0 : m_cnt + 8'd1;
            end
            if (rr && pre > 0) begin
                m_rd_data  = m_q.pop_front();
                m_rd_valid = 1'b1;
                popped     = 1'b1;
            end
            if (want) begin
                if (pre < DEPTH || popped) begin
                    m_q.push_back(m_sample);
                    pushed = 1'b1;
                end else begin
                    m_ovf = 1'b1;
                end
            end
            if (m_state == M_CAP && (ab || (pushed && m_q.size() == DEPTH)))
                m_state = M_DRAIN;
            else if (m_state == M_DRAIN && m_q.size() == 0)
                m_state = M_IDLE;
        end
        m_sample = x;
    endfunction

    task automatic compare_all(input string tag);
        check({tag, ".rd_valid"}, 32'(rd_if.rd_valid), 32'(m_rd_valid));
        check({tag, ".rd_data"},  32'(rd_if.rd_data),  32'(m_rd_data));
        check({tag, ".level"},    32'(rd_if.level),    32'(m_q.size()));
        check({tag, ".empty"},    32'(rd_if.empty),    32'(m_q.size() == 0));
        check({tag, ".full"},     32'(rd_if.full),     32'(m_q.size() == DEPTH));
        check({tag, ".busy"},     32'(busy),           32'(m_state == M_CAP));
        check({tag, ".overflow"}, 32'(overflow),       32'(m_ovf));
    endtask

    // Drive one clock of inputs, advance the model on the edge, compare on
    // the falling edge.
    task automatic step(input bit a, input bit ab, input bit rr, input logic [DW-1:0] x);
        arm          = a;
        abort        = ab;
        rd_if.rd_req = rr;
        adc_d        = x;
        @(posedge clk);
        model_edge(a, ab, rr, decim, x);
        @(negedge clk);
        compare_all("model");
    endtask

    task automatic do_reset();
        rst          = 1'b0;
        arm          = 1'b0;
        abort        = 1'b0;
        rd_if.rd_req = 1'b0;
        adc_d        = '0;
        repeat (2) @(negedge clk);
        model_reset();
        compare_all("reset");
        rst = 1'b1;
    endtask

    initial begin
        decim = 8'd0;
        do_reset();

        // Vector table, decim=1, adc = 0xA0 + index.
        tbl[0]  = '{1, 0, 0, 0, 1, 1, 0, 8'h00};
        tbl[1]  = '{0, 0, 0, 0, 1, 1, 0, 8'h00};
        tbl[2]  = '{0, 0, 0, 1, 1, 0, 0, 8'h00};
        tbl[3]  = '{0, 0, 0, 1, 1, 0, 0, 8'h00};
        tbl[4]  = '{0, 0, 0, 2, 1, 0, 0, 8'h00};
        tbl[5]  = '{0, 0, 1, 1, 1, 0, 1, 8'hA1};
        tbl[6]  = '{0, 1, 0, 1, 0, 0, 0, 8'hA1};
        tbl[7]  = '{1, 0, 0, 1, 0, 0, 0, 8'hA1};
        tbl[8]  = '{0, 0, 1, 0, 0, 1, 1, 8'hA3};
        tbl[9]  = '{0, 0, 1, 0, 0, 1, 0, 8'hA3};
        tbl[10] = '{1, 0, 0, 0, 1, 1, 0, 8'hA3};
        decim = 8'd1;
        for (int i = 0; i < 11; i++) begin
            step(tbl[i].arm, tbl[i].abort, tbl[i].rd_req, 8'(8'hA0 + i));
            check($sformatf("tbl%0d.level", i),    32'(rd_if.level),    32'(tbl[i].level));
            check($sformatf("tbl%0d.busy", i),     32'(busy),           32'(tbl[i].busy));
            check($sformatf("tbl%0d.empty", i),    32'(rd_if.empty),    32'(tbl[i].empty));
            check($sformatf("tbl%0d.rd_valid", i), 32'(rd_if.rd_valid), 32'(tbl[i].rd_valid));
            check($sformatf("tbl%0d.rd_data", i),  32'(rd_if.rd_data),  32'(tbl[i].data));
        end

        // Fill at decim=0 from a ramp, then drain all 16 and one extra request.
        do_reset();
        decim = 8'd0;
        step(1, 0, 0, 8'd0);
        for (int k = 1; k <= 16; k++) step(0, 0, 0, 8'(k));
        check("fill.level", 32'(rd_if.level), 32'd16);
        check("fill.full", 32'(rd_if.full), 32'd1);
        check("fill.busy", 32'(busy), 32'd0);
        check("fill.overflow", 32'(overflow), 32'd0);
        for (int i = 0; i < 16; i++) begin
            step(0, 0, 1, 8'(17 + i));
            check($sformatf("drain%0d.rd_valid", i), 32'(rd_if.rd_valid), 32'd1);
            check($sformatf("drain%0d.rd_data", i), 32'(rd_if.rd_data), 32'(i));
        end
        check("drain.level", 32'(rd_if.level), 32'd0);
        check("drain.empty", 32'(rd_if.empty), 32'd1);
        step(1, 0, 1, 8'd0);
        check("extra_req.rd_valid", 32'(rd_if.rd_valid), 32'd0);
        check("extra_req.level", 32'(rd_if.level), 32'd0);
        check("rearm.busy", 32'(busy), 32'd1);

        // decim=3: one push every 4 clocks, then 8 pops.
        do_reset();
        decim = 8'd3;
        step(1, 0, 0, 8'd0);
        for (int k = 1; k <= 64; k++) step(0, 0, 0, 8'(k));
        check("dec3.full", 32'(rd_if.full), 32'd1);
        for (int i = 0; i < 8; i++) begin
            step(0, 0, 1, 8'(65 + i));
            check($sformatf("dec3_pop%0d.rd_valid", i), 32'(rd_if.rd_valid), 32'd1);
            check($sformatf("dec3_pop%0d.rd_data", i), 32'(rd_if.rd_data), 32'(3 + 4 * i));
        end

        // Streaming: pop every clock while capturing at full rate.
        do_reset();
        decim = 8'd0;
        step(1, 0, 1, 8'd0);
        for (int k = 1; k <= 20; k++) begin
            step(0, 0, 1, 8'(k));
            check($sformatf("stream%0d.level", k), 32'(rd_if.level), 32'd1);
            check($sformatf("stream%0d.full", k), 32'(rd_if.full), 32'd0);
        end
        step(0, 1, 0, 8'd21);
        check("stream_abort.busy", 32'(busy), 32'd0);
        check("stream_abort.level", 32'(rd_if.level), 32'd1);
        step(0, 0, 1, 8'd22);
        check("stream_last.rd_data", 32'(rd_if.rd_data), 32'd19);
        check("stream_last.level", 32'(rd_if.level), 32'd0);
        step(1, 0, 0, 8'd23);
        check("stream_idle.busy", 32'(busy), 32'd1);

        // Asynchronous reset at level 9, then ADC activity without arm.
        do_reset();
        decim = 8'd0;
        step(1, 0, 0, 8'h40);
        for (int k = 1; k <= 10; k++) step(0, 0, k == 10, 8'(8'h40 + k));
        check("pre_rst.level", 32'(rd_if.level), 32'd9);
        check("pre_rst.rd_data", 32'(rd_if.rd_data), 32'h40);
        rst = 1'b0;
        #2;
        model_reset();
        compare_all("async_rst");
        check("async_rst.level", 32'(rd_if.level), 32'd0);
        check("async_rst.rd_data", 32'(rd_if.rd_data), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 10; k++) step(0, 0, 0, 8'($urandom_range(0, 255)));
        check("post_rst.level", 32'(rd_if.level), 32'd0);
        check("post_rst.busy", 32'(busy), 32'd0);

        // arm while draining with level 5 must be ignored.
        do_reset();
        decim = 8'd0;
        step(1, 0, 0, 8'd0);
        for (int k = 1; k <= 5; k++) step(0, 0, 0, 8'(k));
        step(0, 1, 0, 8'd6);
        step(1, 0, 0, 8'd7);
        check("drain_arm.level", 32'(rd_if.level), 32'd5);
        check("drain_arm.busy", 32'(busy), 32'd0);
        check("drain_arm.overflow", 32'(overflow), 32'd0);
        for (int k = 0; k < 5; k++) step(0, 0, 1, 8'd0);
        check("drain_arm_done.level", 32'(rd_if.level), 32'd0);
        step(1, 0, 0, 8'd0);
        check("drain_arm_done.busy", 32'(busy), 32'd1);

        // Random traffic; pop density rises per block, decim changes mid-run.
        do_reset();
        for (int blk = 0; blk < 4; blk++) begin
            decim = 8'($urandom_range(0, 3));
            for (int c = 0; c < 1000; c++) begin
                if (c == 500) decim = 8'($urandom_range(0, 3));
                step($urandom_range(0, 15) == 0,
                     $urandom_range(0, 31) == 0,
                     $urandom_range(0, 3) < blk,
                     8'($urandom_range(0, 255)));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
